// File: rtl/elastic_pipeline.sv
// Elastic register pipeline with a combinational ready chain.
// Bubbles collapse forward even while the output is stalled.
module elastic_pipeline #(
  parameter int DATA_WIDTH      = 8,
  parameter int PIPELINE_LENGTH = 16,
  localparam int OCC_W = $clog2(PIPELINE_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic                  input_valid,
  output logic                  input_ready,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [OCC_W-1:0]      occupancy
);

  localparam int LAST = PIPELINE_LENGTH - 1;

  logic [PIPELINE_LENGTH-1:0] valid_q;
  logic [PIPELINE_LENGTH-1:0] adv;
  logic [PIPELINE_LENGTH-1:0] prev_valid;
  logic [DATA_WIDTH-1:0]      data_q     [PIPELINE_LENGTH];
  logic [DATA_WIDTH-1:0]      prev_data  [PIPELINE_LENGTH];
  logic [OCC_W-1:0]           occ_q;
  logic                       in_hs;
  logic                       out_hs;

  // A stage may move when any stage at or ahead of it is empty.
  always_comb begin : ready_chain
    logic chain;
    chain = output_ready;
    adv   = '0;
    for (int i = LAST; i >= 0; i--) begin
      chain  = chain | ~valid_q[i];
      adv[i] = chain;
    end
  end

  always_comb begin
    prev_valid    = '0;
    prev_valid[0] = in_hs;
    prev_data[0]  = input_data;
    for (int i = 1; i < PIPELINE_LENGTH; i++) begin
      prev_valid[i] = valid_q[i-1];
      prev_data[i]  = data_q[i-1];
    end
  end

  assign input_ready  = rst & adv[0] & ~flush;
  assign in_hs        = input_valid & input_ready;
  assign out_hs       = valid_q[LAST] & output_ready;
  assign output_valid = valid_q[LAST];
  assign output_data  = data_q[LAST];
  assign occupancy    = occ_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < PIPELINE_LENGTH; i++) begin
        if (adv[i]) valid_q[i] <= prev_valid[i];
      end
    end
  end

  // Payload only moves with a valid beat; empty stages keep stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PIPELINE_LENGTH; i++) begin
        data_q[i] <= '0;
      end
    end else if (!flush) begin
      for (int i = 0; i < PIPELINE_LENGTH; i++) begin
        if (adv[i] && prev_valid[i]) data_q[i] <= prev_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else if (in_hs && !out_hs) begin
      occ_q <= occ_q + OCC_W'(1);
    end else if (out_hs && !in_hs) begin
      occ_q <= occ_q - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed bench for elastic_pipeline at default parameters.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_elastic_pipeline;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] input_data = 8'h00;
  logic       input_valid = 1'b0;
  logic       input_ready;
  logic [7:0] output_data;
  logic       output_valid;
  logic       output_ready = 1'b1;
  logic [4:0] occupancy;

  int total = 0;
  int fails = 0;
  int seen;
  logic [7:0] exp_d;

  elastic_pipeline dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    input_valid = v;
    input_data  = d;
    #1;
  endtask

  initial begin
    // reset state, held across an edge
    #2;
    check("rst_ov", output_valid, 1'b0);
    check("rst_od", output_data, 8'h00);
    check("rst_ir", input_ready, 1'b0);
    check("rst_occ", occupancy, 5'd0);
    @(posedge clk); #1;
    check("rst_occ_edge", occupancy, 5'd0);

    // single beat, first edge after release
    @(negedge clk);
    rst = 1'b1;
    input_valid = 1'b1;
    input_data = 8'hDB;
    #1;
    check("a_ir", input_ready, 1'b1);
    for (int c = 1; c < 16; c++) begin
      drive(1'b0, 8'h00);
      check("a_ov_early", output_valid, 1'b0);
      check("a_occ_flight", occupancy, 5'd1);
    end
    drive(1'b0, 8'h00);
    check("a_ov", output_valid, 1'b1);
    check("a_od", output_data, 8'hDB);
    check("a_occ_out", occupancy, 5'd1);
    drive(1'b0, 8'h00);
    check("a_ov_once", output_valid, 1'b0);
    check("a_occ_end", occupancy, 5'd0);

    // back-to-back stream 0x00..0x1F
    for (int c = 0; c < 48; c++) begin
      drive(c < 32, 8'(c));
      if (c < 32) check("b_ir", input_ready, 1'b1);
      if (c >= 16) begin
        check("b_ov", output_valid, 1'b1);
        check("b_od", output_data, 64'(c - 16));
      end else begin
        check("b_ov_fill", output_valid, 1'b0);
      end
    end
    drive(1'b0, 8'h00);
    check("b_ov_end", output_valid, 1'b0);
    check("b_occ_end", occupancy, 5'd0);

    // stalled output, offer 20 beats
    output_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 8'h40 + 8'(c));
      check("c_ir", input_ready, (c < 16) ? 1'b1 : 1'b0);
      check("c_occ", occupancy, (c < 16) ? 64'(c) : 64'd16);
    end
    for (int d = 0; d < 16; d++) begin
      @(negedge clk);
      output_ready = 1'b1;
      input_valid = 1'b0;
      #1;
      if (d == 0) check("c_ir_release", input_ready, 1'b1);
      check("c_ov", output_valid, 1'b1);
      check("c_od", output_data, 8'h40 + 8'(d));
      check("c_occ_drain", occupancy, 64'(16 - d));
    end
    drive(1'b0, 8'h00);
    check("c_ov_end", output_valid, 1'b0);
    check("c_occ_end", occupancy, 5'd0);

    // full pipeline streaming one in, one out
    output_ready = 1'b0;
    for (int c = 0; c < 16; c++) drive(1'b1, 8'h80 + 8'(c));
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      output_ready = 1'b1;
      input_valid = 1'b1;
      input_data = 8'h90 + 8'(j);
      #1;
      check("d_occ_full", occupancy, 5'd16);
      check("d_ir", input_ready, 1'b1);
      check("d_ov", output_valid, 1'b1);
      check("d_od", output_data, 8'h80 + 8'(j));
    end
    for (int j = 8; j < 24; j++) begin
      drive(1'b0, 8'h00);
      exp_d = (j < 16) ? 8'h80 + 8'(j) : 8'h90 + 8'(j - 16);
      check("d_od_drain", output_data, exp_d);
      check("d_occ_drain", occupancy, 64'(24 - j));
    end
    drive(1'b0, 8'h00);
    check("d_ov_end", output_valid, 1'b0);

    // flush with five beats in flight
    for (int c = 0; c < 5; c++) drive(1'b1, 8'hA0 + 8'(c));
    @(negedge clk);
    flush = 1'b1;
    input_valid = 1'b1;
    input_data = 8'hEE;
    #1;
    check("e_ir_flush", input_ready, 1'b0);
    check("e_occ_pre", occupancy, 5'd5);
    @(negedge clk);
    flush = 1'b0;
    input_valid = 1'b0;
    #1;
    check("e_occ_post", occupancy, 5'd0);
    check("e_ov_post", output_valid, 1'b0);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      drive(1'b0, 8'h00);
      if (output_valid) seen++;
    end
    check("e_no_output", seen, 0);

    // asynchronous reset mid-stream
    for (int c = 0; c < 18; c++) drive(1'b1, 8'hC0 + 8'(c));
    check("f_ov_pre", output_valid, 1'b1);
    check("f_od_pre", output_data, 8'hC1);
    #2;
    rst = 1'b0;
    #1;
    check("f_ov_rst", output_valid, 1'b0);
    check("f_occ_rst", occupancy, 5'd0);
    check("f_ir_rst", input_ready, 1'b0);
    check("f_od_rst", output_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    input_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 8'h00);
      if (output_valid) seen++;
    end
    check("f_no_output", seen, 0);
    drive(1'b1, 8'h5A);
    check("f_ir_new", input_ready, 1'b1);
    seen = 0;
    for (int c = 1; c <= 16; c++) begin
      drive(1'b0, 8'h00);
      if (c < 16 && output_valid) seen++;
    end
    check("f_no_early", seen, 0);
    check("f_ov_new", output_valid, 1'b1);
    check("f_od_new", output_data, 8'h5A);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
